// File: rtl/assist_target_ramp_if.sv
// rtl/assist_target_ramp_if.sv - operand/result bundle of the assist target-current ramp
interface assist_target_ramp_if #(
    parameter int TORQUE_W = 12,
    parameter int CAD_W    = 5,
    parameter int INCL_W   = 13,
    parameter int SCALE_W  = 3,
    parameter int CURR_W   = 12
);
    logic                vld;
    logic [TORQUE_W-1:0] avg_torque;
    logic [CAD_W-1:0]    cadence;
    logic                not_pedaling;
    logic [INCL_W-1:0]   incline;
    logic [SCALE_W-1:0]  scale;
    logic [CURR_W-1:0]   target_curr;
    logic                curr_vld;
    logic                busy;

    modport master (
        output vld, avg_torque, cadence, not_pedaling, incline, scale,
        input  target_curr, curr_vld, busy
    );

    modport slave (
        input  vld, avg_torque, cadence, not_pedaling, incline, scale,
        output target_curr, curr_vld, busy
    );
endinterface

// File: rtl/assist_target_ramp.sv
// rtl/assist_target_ramp.sv - multi-cycle pedal-assist target current with slew limiting
module assist_target_ramp #(
    parameter int          TORQUE_W   = 12,
    parameter int unsigned TORQUE_MIN = 'h380,
    parameter int          CAD_W      = 5,
    parameter int          INCL_W     = 13,
    parameter int          SCALE_W    = 3,
    parameter int          CURR_W     = 12,
    parameter int          SHIFT      = 15,
    parameter int unsigned RAMP_UP    = 'h040,
    parameter int unsigned RAMP_DN    = 'h080
) (
    input logic                 clk,
    input logic                 rst_n,
    assist_target_ramp_if.slave bus
);

    localparam int P  = TORQUE_W + 9 + CAD_W + 1 + SCALE_W;
    localparam int HI = SHIFT + CURR_W;

    localparam logic [TORQUE_W:0]      TMIN_X   = TORQUE_MIN[TORQUE_W:0];
    localparam logic [CURR_W-1:0]      RU_X     = CURR_W'(RAMP_UP);
    localparam logic [CURR_W-1:0]      RD_X     = CURR_W'(RAMP_DN);
    localparam logic signed [INCL_W-1:0] INCL_MAX = INCL_W'(511);
    localparam logic signed [INCL_W-1:0] INCL_MIN = INCL_W'(-512);

    typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, UPD} state_t;

    state_t              state;
    logic [TORQUE_W-1:0] torque_q;
    logic [8:0]          incl_q;
    logic [CAD_W:0]      cad_q;
    logic [SCALE_W-1:0]  scale_q;
    logic                np_q;
    logic [P-1:0]        prod;
    logic [CURR_W-1:0]   tc_q;
    logic                curr_vld_q;

    logic signed [INCL_W-1:0] incl_sat;
    logic [INCL_W:0]          incl_sum;
    logic [8:0]               incl_lim;
    logic [CAD_W:0]           cad_f;
    logic [TORQUE_W:0]        torque_diff;
    logic [TORQUE_W-1:0]      torque_pos;
    logic [CURR_W-1:0]        raw;
    logic [CURR_W-1:0]        step;
    logic [CURR_W-1:0]        tc_next;

    // Operand pre-processing on the live inputs, captured only on the accepting edge
    always_comb begin
        incl_sat = $signed(bus.incline);
        if ($signed(bus.incline) > INCL_MAX)
            incl_sat = INCL_MAX;
        else if ($signed(bus.incline) < INCL_MIN)
            incl_sat = INCL_MIN;
        // Offset into the positive range; the sign bit of the widened sum flags a negative result
        incl_sum = {incl_sat[INCL_W-1], incl_sat} + (INCL_W+1)'(256);
        if (incl_sum[INCL_W])
            incl_lim = '0;
        else if (incl_sum > (INCL_W+1)'(511))
            incl_lim = 9'd511;
        else
            incl_lim = incl_sum[8:0];
        // Cadence below 2 counts as standing still
        cad_f       = (|bus.cadence[CAD_W-1:1]) ? {1'b1, bus.cadence} : '0;
        torque_diff = {1'b0, bus.avg_torque} - TMIN_X;
        torque_pos  = torque_diff[TORQUE_W] ? '0 : torque_diff[TORQUE_W-1:0];
    end

    // Saturate the product and slew-limit toward it; differences are only formed
    // in the direction where they are non-negative, so nothing wraps or overshoots
    always_comb begin
        raw     = (|prod[P-1:HI]) ? '1 : prod[HI-1:SHIFT];
        step    = '0;
        tc_next = tc_q;
        if (np_q) begin
            tc_next = '0;
        end else if (raw > tc_q) begin
            step    = raw - tc_q;
            if (RAMP_UP != 0 && step > RU_X)
                step = RU_X;
            tc_next = tc_q + step;
        end else if (raw < tc_q) begin
            step    = tc_q - raw;
            if (RAMP_DN != 0 && step > RD_X)
                step = RD_X;
            tc_next = tc_q - step;
        end
    end

    // Sequencer: capture, three multiplies, then update with a one-cycle valid pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            torque_q   <= '0;
            incl_q     <= '0;
            cad_q      <= '0;
            scale_q    <= '0;
            np_q       <= 1'b0;
            prod       <= '0;
            tc_q       <= '0;
            curr_vld_q <= 1'b0;
        end else begin
            curr_vld_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.vld) begin
                        torque_q <= torque_pos;
                        incl_q   <= incl_lim;
                        cad_q    <= cad_f;
                        scale_q  <= bus.scale;
                        np_q     <= bus.not_pedaling;
                        state    <= MUL1;
                    end
                end
                MUL1: begin
                    prod  <= P'(torque_q) * P'(incl_q);
                    state <= MUL2;
                end
                MUL2: begin
                    prod  <= prod * P'(cad_q);
                    state <= MUL3;
                end
                MUL3: begin
                    prod  <= prod * P'(scale_q);
                    state <= UPD;
                end
                UPD: begin
                    tc_q       <= tc_next;
                    curr_vld_q <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.target_curr = tc_q;
    assign bus.curr_vld    = curr_vld_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_assist_target_ramp.sv
// tb/tb_assist_target_ramp.sv - self-checking bench for assist_target_ramp
module tb_assist_target_ramp;

    localparam int TORQUE_MIN = 'h380;
    localparam int RUP        = 'h040;
    localparam int RDN        = 'h080;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    assist_target_ramp_if bus();
    assist_target_ramp_if bus_sat();

    assist_target_ramp u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assist_target_ramp #(.RAMP_UP(0)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_sat)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int model_tc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Assist current from the rider inputs, in plain integer arithmetic
    function automatic int model_raw(input int torque, input int incl13, input int cad, input int sc);
        int     tp;
        int     is;
        int     il;
        int     cf;
        longint p;
        longint r;
        tp = torque - TORQUE_MIN;
        if (tp < 0) tp = 0;
        is = (incl13 >= 4096) ? incl13 - 8192 : incl13;
        if (is > 511)  is = 511;
        if (is < -512) is = -512;
        il = is + 256;
        if (il < 0)   il = 0;
        if (il > 511) il = 511;
        cf = (cad >= 2) ? cad + 32 : 0;
        p  = longint'(tp) * il * cf * sc;
        r  = p >> 15;
        if (r > 4095) r = 4095;
        return int'(r);
    endfunction

    function automatic int model_next(input int tc, input int raw, input int np, input int up, input int dn);
        int d;
        if (np != 0) return 0;
        if (raw > tc) begin
            d = raw - tc;
            if (up != 0 && d > up) d = up;
            return tc + d;
        end
        if (raw < tc) begin
            d = tc - raw;
            if (dn != 0 && d > dn) d = dn;
            return tc - d;
        end
        return tc;
    endfunction

    task automatic drive(input int torque, input int incl, input int cad, input int sc, input int np);
        bus.avg_torque   = 12'(torque);
        bus.incline      = 13'(incl);
        bus.cadence      = 5'(cad);
        bus.scale        = 3'(sc);
        bus.not_pedaling = (np != 0);
    endtask

    // One full transaction starting in IDLE, #1 after a rising edge
    task automatic do_op(input int torque, input int incl, input int cad, input int sc,
                         input int np, input int exp, input string tag);
        drive(torque, incl, cad, sc, np);
        bus.vld = 1'b1;
        @(posedge clk); #1;
        bus.vld = 1'b0;
        // Garbage on the inputs while the computation is in flight
        drive(int'($urandom_range(0, 4095)), int'($urandom_range(0, 8191)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
        check({tag, ".busy0"}, 32'(bus.busy), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check({tag, ".busy"}, 32'(bus.busy), 32'd1);
            check({tag, ".early_vld"}, 32'(bus.curr_vld), 32'd0);
        end
        @(posedge clk); #1;
        check({tag, ".curr_vld"}, 32'(bus.curr_vld), 32'd1);
        check({tag, ".idle"}, 32'(bus.busy), 32'd0);
        check({tag, ".target"}, 32'(bus.target_curr), 32'(exp));
        model_tc = exp;
    endtask

    task automatic ramp_to_120(input string tag);
        do_op('h480, 0, 16, 3, 0, 'h040, {tag, ".up1"});
        do_op('h480, 0, 16, 3, 0, 'h080, {tag, ".up2"});
        do_op('h480, 0, 16, 3, 0, 'h0C0, {tag, ".up3"});
        do_op('h480, 0, 16, 3, 0, 'h100, {tag, ".up4"});
        do_op('h480, 0, 16, 3, 0, 'h120, {tag, ".up5"});
    endtask

    initial begin
        logic [19:0] pattern;
        logic [19:0] pattern_exp;
        int          pulses;
        int          t, inc, cd, sc, np, ex;

        bus.vld = 1'b0;
        drive(0, 0, 0, 0, 0);
        bus_sat.vld          = 1'b0;
        bus_sat.avg_torque   = '0;
        bus_sat.incline      = '0;
        bus_sat.cadence      = '0;
        bus_sat.scale        = '0;
        bus_sat.not_pedaling = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst.target", 32'(bus.target_curr), 32'd0);
        check("rst.curr_vld", 32'(bus.curr_vld), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.sat_target", 32'(bus_sat.target_curr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal ramp-up
        ramp_to_120("nom");

        // Saturation with unlimited ramp-up
        bus_sat.avg_torque = 12'hFFF;
        bus_sat.incline    = 13'h0FF;
        bus_sat.cadence    = 5'd31;
        bus_sat.scale      = 3'd7;
        bus_sat.vld        = 1'b1;
        @(posedge clk); #1;
        bus_sat.vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sat.early_vld", 32'(bus_sat.curr_vld), 32'd0);
        @(posedge clk); #1;
        check("sat.curr_vld", 32'(bus_sat.curr_vld), 32'd1);
        check("sat.target", 32'(bus_sat.target_curr), 32'hFFF);

        // Ramp-down through the three dead-bands
        do_op('h480, 'h1E00, 16, 3, 0, 'h0A0, "dn_incl.1");
        do_op('h480, 'h1E00, 16, 3, 0, 'h020, "dn_incl.2");
        do_op('h480, 'h1E00, 16, 3, 0, 'h000, "dn_incl.3");
        ramp_to_120("re1");
        do_op('h480, 0, 1, 3, 0, 'h0A0, "dn_cad.1");
        do_op('h480, 0, 1, 3, 0, 'h020, "dn_cad.2");
        do_op('h480, 0, 1, 3, 0, 'h000, "dn_cad.3");
        ramp_to_120("re2");
        do_op('h37F, 0, 16, 3, 0, 'h0A0, "dn_trq.1");
        do_op('h37F, 0, 16, 3, 0, 'h020, "dn_trq.2");
        do_op('h37F, 0, 16, 3, 0, 'h000, "dn_trq.3");

        // not_pedaling drops straight to zero
        ramp_to_120("re3");
        do_op('h480, 0, 16, 3, 1, 'h000, "np");

        // vld held high: one accept every five cycles
        drive('h480, 0, 16, 3, 0);
        bus.vld     = 1'b1;
        pattern     = '0;
        pattern_exp = '0;
        pulses      = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            pattern[c]     = bus.curr_vld;
            pattern_exp[c] = ((c % 5) == 4);
            if (bus.curr_vld) pulses++;
        end
        bus.vld = 1'b0;
        check("held.pattern", 32'(pattern), 32'(pattern_exp));
        check("held.pulses", 32'(pulses), 32'd4);
        check("held.target", 32'(bus.target_curr), 32'h100);
        model_tc = 'h100;

        // Reset during MUL2
        drive('h480, 0, 16, 3, 0);
        bus.vld = 1'b1;
        @(posedge clk); #1;
        bus.vld = 1'b0;
        @(posedge clk); #1;
        check("mid.busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid.busy", 32'(bus.busy), 32'd0);
        check("mid.curr_vld", 32'(bus.curr_vld), 32'd0);
        check("mid.target", 32'(bus.target_curr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        model_tc = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("mid.no_vld", 32'(bus.curr_vld), 32'd0);
        end
        check("mid.target_after", 32'(bus.target_curr), 32'd0);

        // Randomized transactions against the reference model
        for (int i = 0; i < 30; i++) begin
            t  = int'($urandom_range('h300, 'hFFF));
            if ($urandom_range(0, 1) == 0)
                inc = int'($urandom_range(0, 8191));
            else
                inc = (int'($urandom_range(0, 1100)) - 550) & 'h1FFF;
            cd = int'($urandom_range(0, 31));
            sc = int'($urandom_range(0, 7));
            np = ($urandom_range(0, 7) == 0) ? 1 : 0;
            ex = model_next(model_tc, model_raw(t, inc, cd, sc), np, RUP, RDN);
            do_op(t, inc, cd, sc, np, ex, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
